// File: rtl/rvfi_imem_pkg.sv
// Shared types and constants for the formal-harness instruction memory responder.
package rvfi_imem_pkg;

    // One 16-bit instruction halfword
    typedef logic [15:0] imem_half_t;

    // Payload held in each response queue entry
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

    // Byte distance between the two halfword lanes of a fetched word
    localparam int IMEM_HALF_BYTES = 2;

    // Pick the checker's halfword on an address hit, otherwise the free fill halfword
    function automatic imem_half_t lane_pick(input logic hit, input imem_half_t match,
                                             input imem_half_t fill);
        return hit ? match : fill;
    endfunction

endpackage

// File: rtl/rvfi_imem_rspq.sv
// In-order response queue. Each entry carries an age counter that saturates at
// LATENCY; the head may only leave once it has aged that far.
module rvfi_imem_rspq
    import rvfi_imem_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  imem_rsp_t push_rsp,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output logic      head_ready,
    output imem_rsp_t head_rsp
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [2:0]  AGE_MAX = 3'(LATENCY);

    // Index bits plus one wrap bit so full and empty are told apart by compare
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    imem_rsp_t       mem [DEPTH];
    logic [2:0]      age [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    // Guard locally so a misbehaving caller cannot corrupt the pointers
    assign do_push = push && !full;
    assign do_pop  = pop && head_ready;

    assign head_ready = !empty && (age[rd_idx] == AGE_MAX);
    // Empty queue presents zeros rather than stale payload
    assign head_rsp   = empty ? '0 : mem[rd_idx];

    // Read/write pointer advance; reset discards every entry in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage; contents of free slots are never observed
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_idx] <= push_rsp;
    end

    // Per-slot aging: the push cycle itself counts as the first cycle of age,
    // so a request accepted in cycle t is ready in cycle t+LATENCY
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                age[i] <= '0;
            end else if (do_push && (wr_idx == AW'(i))) begin
                age[i] <= 3'd1;
            end else if (age[i] != AGE_MAX) begin
                age[i] <= age[i] + 3'd1;
            end
        end
    end

endmodule

// File: rtl/rvfi_imem_responder.sv
// Fetch responder for the formal harness: halfwords at imem_addr return
// imem_data, all others return free fill data, through a latency/backpressure queue.
module rvfi_imem_responder
    import rvfi_imem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [31:0]     fill_data,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            rsp_err
);

    logic [XLEN-1:0] lane1_addr;
    logic            hit0;
    logic            hit1;
    logic            misaligned;
    imem_rsp_t       push_rsp;
    imem_rsp_t       head_rsp;
    logic            q_full;
    logic            q_empty;
    logic            q_head_ready;
    logic            push;
    logic            pop;

    // Upper lane address wraps modulo 2^XLEN
    assign lane1_addr = req_addr + XLEN'(IMEM_HALF_BYTES);
    assign hit0       = (req_addr == imem_addr);
    assign hit1       = (lane1_addr == imem_addr);
    assign misaligned = req_addr[0];

    // Build the response payload at acceptance; misaligned fetches pass fill through
    always_comb begin
        push_rsp = '0;
        if (misaligned) begin
            push_rsp.data = fill_data;
            push_rsp.err  = 1'b1;
        end else begin
            push_rsp.data[15:0]  = lane_pick(hit0, imem_data, fill_data[15:0]);
            push_rsp.data[31:16] = lane_pick(hit1, imem_data, fill_data[31:16]);
            push_rsp.err         = 1'b0;
        end
    end

    // No pass-through when full: a pop frees a slot only for the next cycle
    assign req_ready = !q_full && !reset;
    assign push      = req_valid && req_ready;
    assign rsp_valid = q_head_ready && !reset;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = reset ? 32'd0 : head_rsp.data;
    assign rsp_err   = reset ? 1'b0  : head_rsp.err;

    rvfi_imem_rspq #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_rspq (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_rsp   (push_rsp),
        .pop        (pop),
        .full       (q_full),
        .empty      (q_empty),
        .head_ready (q_head_ready),
        .head_rsp   (head_rsp)
    );

    // q_empty is folded into head_ready/head_rsp inside the queue
    logic unused_ok;
    assign unused_ok = q_empty;

endmodule

// File: tb/tb_rvfi_imem_responder.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model.
module tb_rvfi_imem_responder;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int LAT = 2;

    logic            clock;
    logic            reset;
    logic [XLEN-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [31:0]     fill_data;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic            rsp_err;

    rvfi_imem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .fill_data(fill_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          t;
    } ent_t;

    ent_t mq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   fresh = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Expected fetch result straight from the address-matching rules
    function automatic ent_t model_fetch(input logic [31:0] a, input logic [31:0] f);
        ent_t e;
        logic [31:0] a1;
        e.t = cyc;
        if (a[0]) begin
            e.data = f;
            e.err  = 1'b1;
        end else begin
            a1 = a + 32'd2;
            e.data[15:0]  = (a == imem_addr)  ? imem_data : f[15:0];
            e.data[31:16] = (a1 == imem_addr) ? imem_data : f[31:16];
            e.err = 1'b0;
        end
        return e;
    endfunction

    // One clock cycle: drive, compare against model, advance model
    task automatic step(input logic rv, input logic [31:0] a, input logic [31:0] f,
                        input logic rr, input logic rst);
        logic exp_ready;
        logic exp_valid;
        @(negedge clock);
        req_valid = rv; req_addr = a; fill_data = f; rsp_ready = rr; reset = rst;
        #1;
        exp_ready = !rst && (mq.size() < DEPTH);
        exp_valid = !rst && (mq.size() > 0) && (cyc >= mq[0].t + LAT);
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("rsp_data", rsp_data, mq[0].data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, mq[0].err});
        end else if (rst || fresh) begin
            chk("rsp_data_zero", rsp_data, 32'd0);
            chk("rsp_err_zero", {31'd0, rsp_err}, 32'd0);
        end
        if (rst) begin
            mq.delete();
            fresh = 1'b1;
        end else begin
            if (exp_valid && rr) void'(mq.pop_front());
            if (rv && exp_ready) begin
                mq.push_back(model_fetch(a, f));
                fresh = 1'b0;
            end
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] off;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; fill_data = '0; rsp_ready = 1'b0;
        imem_addr = 32'h100; imem_data = 16'hABCD;

        // Reset state and first cycle after reset
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Lane matching: hit low lane, hit high lane, no hit
        step(1'b1, 32'h100, 32'h11223344, 1'b1, 1'b0);
        idle(LAT + 1);
        step(1'b1, 32'h0FE, 32'h11223344, 1'b1, 1'b0);
        step(1'b1, 32'h104, 32'h11223344, 1'b1, 1'b0);
        idle(LAT + 1);

        // Misaligned request followed by an aligned one, kept in order
        step(1'b1, 32'h101, 32'hDEADBEEF, 1'b1, 1'b0);
        step(1'b1, 32'h100, 32'h11223344, 1'b1, 1'b0);
        idle(LAT + 2);

        // Upper lane wraps past the top of the address space
        imem_addr = 32'h0; imem_data = 16'h5555;
        step(1'b1, 32'hFFFFFFFE, 32'h11223344, 1'b1, 1'b0);
        idle(LAT + 1);
        imem_addr = 32'h100; imem_data = 16'hABCD;

        // Fill under stall, hold 10 cycles, then drain and admit the 5th
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0FC + 32'(2 * i), $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 32'h200, 32'hCAFEF00D, 1'b1, 1'b0);
        idle(LAT + 4);

        // Reset with entries in flight: they must never come back
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(LAT + 4);

        // Full-rate back-to-back traffic
        for (int i = 0; i < 20; i++) step(1'b1, 32'h100 + 32'(2 * (i % 4)), $urandom, 1'b1, 1'b0);
        idle(LAT + 2);

        // Random traffic around the matching address
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0: off = 32'd0;
                1: off = 32'hFFFFFFFE;
                2: off = 32'd2;
                3: off = 32'd1;
                4: off = 32'hFFFFFFFF;
                5: off = {$urandom_range(0, 255), 1'b0};
                default: off = $urandom;
            endcase
            a = imem_addr + off;
            step(1'($urandom_range(0, 3) != 0), a, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end
        idle(DEPTH + LAT + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
